// File: rtl/hs_operator_pkg.sv
// Shared types and the operator datapath for hs_operator_buf.
// HS_OPERATOR_SAT_EN selects saturating arithmetic; undefined gives modular wrap.
package hs_operator_pkg;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_ADDI,
    OP_SUBI,
    OP_MULI,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_PASS
  } op_e;

  localparam int unsigned MAX_INPUT_SIZE  = 4;
  localparam int unsigned MAX_OUTPUT_SIZE = 8;
  localparam int unsigned MAX_DATA_WIDTH  = 64;

`ifdef HS_OPERATOR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef logic [MAX_DATA_WIDTH-1:0]   word_t;
  typedef logic [2*MAX_DATA_WIDTH-1:0] wide_t;
  typedef word_t [MAX_INPUT_SIZE-1:0]  operands_t;

  // Folds the operands left to right in a double-width accumulator so that carry, borrow and
  // high product bits are visible for saturation before truncating to the datapath width.
  function automatic word_t compute(operands_t opnd, int unsigned n_ops, int unsigned width,
                                    op_e op, word_t imm);
    wide_t       mask;
    wide_t       acc;
    wide_t       rhs;
    wide_t       prod;
    logic        ovf;
    logic        imm_op;
    int unsigned n_terms;

    mask    = (wide_t'(1) << width) - wide_t'(1);
    imm_op  = op inside {OP_ADDI, OP_SUBI, OP_MULI};
    n_terms = imm_op ? 2 : ((op == OP_PASS) ? 1 : n_ops);
    acc     = {{MAX_DATA_WIDTH{1'b0}}, opnd[0]} & mask;
    ovf     = 1'b0;

    for (int unsigned i = 1; i < MAX_INPUT_SIZE; i++) begin
      if (i < n_terms) begin
        rhs = {{MAX_DATA_WIDTH{1'b0}}, (imm_op ? imm : opnd[i])} & mask;
        case (op)
          OP_ADD, OP_ADDI: begin
            acc = acc + rhs;
            if (|(acc & ~mask)) ovf = 1'b1;
            acc = acc & mask;
          end
          OP_SUB, OP_SUBI: begin
            if (rhs > acc) ovf = 1'b1;
            acc = (acc - rhs) & mask;
          end
          OP_MUL, OP_MULI: begin
            prod = acc * rhs;
            if (|(prod & ~mask)) ovf = 1'b1;
            acc = prod & mask;
          end
          OP_AND:  acc = acc & rhs;
          OP_OR:   acc = acc | rhs;
          OP_XOR:  acc = acc ^ rhs;
          default: ;
        endcase
      end
    end

    if (SAT_EN && ovf) begin
      acc = (op inside {OP_SUB, OP_SUBI}) ? '0 : mask;
    end
    return acc[MAX_DATA_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/hs_result_fifo.sv
// Register FIFO holding computed results until every consumer has taken the head entry.
module hs_result_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign occupancy = cnt_q;

  if (DEPTH == 1) begin : g_single
    logic [WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_q <= '0;
      end else if (push) begin
        mem_q <= wdata;
      end
    end

    assign rdata = mem_q;
  end else begin : g_multi
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;

    // Push into a full FIFO is only issued alongside a pop, so the write lands in the slot
    // that the read pointer is leaving.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_q  <= '{default: '0};
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wptr_q] <= wdata;
          wptr_q        <= wptr_q + 1'b1;
        end
        if (pop) begin
          rptr_q <= rptr_q + 1'b1;
        end
      end
    end

    assign rdata = mem_q[rptr_q];
  end

endmodule

// File: rtl/hs_operator_buf.sv
// Handshake operator node: gathers one operand per channel, computes, buffers the result and
// serves each consumer once per entry. HS_OPERATOR_SAT_EN selects saturating arithmetic.
module hs_operator_buf
  import hs_operator_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           INPUT_SIZE  = 2,
  parameter int unsigned           OUTPUT_SIZE = 2,
  parameter op_e                   OP          = OP_ADD,
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0,
  parameter int unsigned           DEPTH       = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [$clog2(DEPTH):0]           occupancy,
  output logic [31:0]                      result_count
);

  if (INPUT_SIZE < 1 || INPUT_SIZE > MAX_INPUT_SIZE) begin : g_bad_input_size
    $error("hs_operator_buf: INPUT_SIZE must be 1..%0d", MAX_INPUT_SIZE);
  end
  if (OUTPUT_SIZE < 1 || OUTPUT_SIZE > MAX_OUTPUT_SIZE) begin : g_bad_output_size
    $error("hs_operator_buf: OUTPUT_SIZE must be 1..%0d", MAX_OUTPUT_SIZE);
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_DATA_WIDTH) begin : g_bad_data_width
    $error("hs_operator_buf: DATA_WIDTH must be 1..%0d", MAX_DATA_WIDTH);
  end
  if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hs_operator_buf: DEPTH must be a power of two");
  end
  if ((OP == OP_ADDI || OP == OP_SUBI || OP == OP_MULI || OP == OP_PASS) && INPUT_SIZE != 1)
  begin : g_bad_unary
    $error("hs_operator_buf: immediate and PASS ops need INPUT_SIZE == 1");
  end

  logic [INPUT_SIZE-1:0]  has_q, has_d;
  logic [INPUT_SIZE-1:0]  req_l_q, req_l_d;
  logic [DATA_WIDTH-1:0]  opnd_q [INPUT_SIZE];
  logic [DATA_WIDTH-1:0]  opnd_d [INPUT_SIZE];
  logic [OUTPUT_SIZE-1:0] served_q, served_d;
  logic [OUTPUT_SIZE-1:0] ack_r_q, ack_r_d;
  logic [OUTPUT_SIZE-1:0] all_done;
  logic [DATA_WIDTH-1:0]  last_q;
  logic [DATA_WIDTH-1:0]  head;
  logic [DATA_WIDTH-1:0]  result;
  logic [31:0]            result_count_q;
  operands_t              opnd;
  logic                   push, pop, full, empty;

  // Capture: an ack on a channel that already holds an operand is dropped.
  always_comb begin
    has_d   = has_q;
    req_l_d = req_l_q;
    opnd_d  = opnd_q;
    for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
      if (ack_l[i] && !has_q[i]) begin
        opnd_d[i]  = din[DATA_WIDTH*i +: DATA_WIDTH];
        has_d[i]   = 1'b1;
        req_l_d[i] = 1'b0;
      end else begin
        if (push) has_d[i] = 1'b0;
        if (!has_q[i] && !req_l_q[i]) req_l_d[i] = 1'b1;
      end
    end
  end

  always_comb begin
    opnd = '0;
    for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
      opnd[i] = word_t'(opnd_q[i]);
    end
  end

  assign result = DATA_WIDTH'(compute(opnd, INPUT_SIZE, DATA_WIDTH, OP, word_t'(IMMEDIATE)));

  // The head pops once the ack currently on the wire completes the served set; no new ack is
  // granted in that cycle since the head is about to change.
  assign all_done = served_q | ack_r_q;
  assign pop      = !empty && (&all_done);
  assign push     = (&has_q) && (!full || pop);

  always_comb begin
    served_d = pop ? '0 : all_done;
    ack_r_d  = '0;
    if (!empty && !pop) begin
      ack_r_d = req_r & ~all_done;
    end
  end

  hs_result_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .wdata     (result),
    .rdata     (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_q          <= '0;
      req_l_q        <= '0;
      opnd_q         <= '{default: '0};
      served_q       <= '0;
      ack_r_q        <= '0;
      last_q         <= '0;
      result_count_q <= '0;
    end else begin
      has_q    <= has_d;
      req_l_q  <= req_l_d;
      opnd_q   <= opnd_d;
      served_q <= served_d;
      ack_r_q  <= ack_r_d;
      if (pop) last_q <= head;
      if (push) result_count_q <= result_count_q + 32'd1;
    end
  end

  assign req_l        = req_l_q;
  assign ack_r        = ack_r_q;
  assign dout         = empty ? last_q : head;
  assign result_count = result_count_q;

endmodule

// File: tb/tb_hs_operator_buf.sv
// Directed bench for hs_operator_buf: ADD node with two consumers, SUB node and DEPTH=1 MULI node.
module tb_hs_operator_buf;
  import hs_operator_pkg::*;

`ifdef HS_OPERATOR_SAT_EN
  localparam logic [7:0] EXP_SUB = 8'h00;
  localparam logic [7:0] EXP_MUL = 8'hFF;
`else
  localparam logic [7:0] EXP_SUB = 8'hFE;
  localparam logic [7:0] EXP_MUL = 8'h20;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ADD node: 32-bit, two operands, two consumers, depth 2
  logic [1:0]  a_req_l, a_ack_l, a_req_r, a_ack_r;
  logic [63:0] a_din;
  logic [31:0] a_dout, a_cnt;
  logic [1:0]  a_occ;

  // SUB node: 8-bit, two operands, one consumer
  logic [1:0]  s_req_l, s_ack_l;
  logic [0:0]  s_req_r, s_ack_r;
  logic [15:0] s_din;
  logic [7:0]  s_dout;
  logic [1:0]  s_occ;
  logic [31:0] s_cnt;

  // MULI node: 8-bit, single operand, depth 1
  logic [0:0]  m_req_l, m_ack_l, m_req_r, m_ack_r;
  logic [7:0]  m_din, m_dout;
  logic [0:0]  m_occ;
  logic [31:0] m_cnt;

  hs_operator_buf #(
    .DATA_WIDTH (32), .INPUT_SIZE (2), .OUTPUT_SIZE (2), .OP (OP_ADD),
    .IMMEDIATE (32'd0), .DEPTH (2)
  ) dut_a (
    .clk (clk), .rst (rst), .req_l (a_req_l), .ack_l (a_ack_l), .din (a_din),
    .req_r (a_req_r), .ack_r (a_ack_r), .dout (a_dout), .occupancy (a_occ),
    .result_count (a_cnt)
  );

  hs_operator_buf #(
    .DATA_WIDTH (8), .INPUT_SIZE (2), .OUTPUT_SIZE (1), .OP (OP_SUB),
    .IMMEDIATE (8'd0), .DEPTH (2)
  ) dut_s (
    .clk (clk), .rst (rst), .req_l (s_req_l), .ack_l (s_ack_l), .din (s_din),
    .req_r (s_req_r), .ack_r (s_ack_r), .dout (s_dout), .occupancy (s_occ),
    .result_count (s_cnt)
  );

  hs_operator_buf #(
    .DATA_WIDTH (8), .INPUT_SIZE (1), .OUTPUT_SIZE (1), .OP (OP_MULI),
    .IMMEDIATE (8'd3), .DEPTH (1)
  ) dut_m (
    .clk (clk), .rst (rst), .req_l (m_req_l), .ack_l (m_ack_l), .din (m_din),
    .req_r (m_req_r), .ack_r (m_ack_r), .dout (m_dout), .occupancy (m_occ),
    .result_count (m_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int prod_k [2];
  int exp_idx [2];
  int base_k;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    a_ack_l = '0; a_req_r = '0; a_din = '0;
    s_ack_l = '0; s_req_r = '0; s_din = '0;
    m_ack_l = '0; m_req_r = '0; m_din = '0;
  endtask

  // Leaves the bench at the first negedge after release, where req_l has just risen.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      prod_k[i]  = 0;
      exp_idx[i] = 0;
    end
  endtask

  // One negedge of the ADD node: score consumer acks, then answer pending operand requests.
  task automatic step_a();
    for (int j = 0; j < 2; j++) begin
      if (a_ack_r[j]) begin
        check_eq($sformatf("a_dout_c%0d_n%0d", j, exp_idx[j]), 64'(a_dout),
                 64'(2 * (base_k + exp_idx[j])));
        check_eq("a_occ_le2", 64'(a_occ <= 2'd2), 64'd1);
        exp_idx[j]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (a_req_l[i]) begin
        a_ack_l[i]         = 1'b1;
        a_din[32*i +: 32]  = 32'(base_k + prod_k[i]);
        prod_k[i]++;
      end else begin
        a_ack_l[i] = 1'b0;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic got_s;
    logic got_m;
    logic got_a;

    rst = 1'b0;
    clear_inputs();
    base_k = 0;

    // Reset state
    @(negedge clk);
    check_eq("rst_req_l", 64'(a_req_l), 64'd0);
    check_eq("rst_ack_r", 64'(a_ack_r), 64'd0);
    check_eq("rst_dout", 64'(a_dout), 64'd0);
    check_eq("rst_occ", 64'(a_occ), 64'd0);
    check_eq("rst_count", 64'(a_cnt), 64'd0);

    // 5 + 7, both operands acked together; ack_r two edges after the ack edge
    rst = 1'b1;
    @(negedge clk);
    check_eq("req_l_first", 64'(a_req_l), 64'h3);
    a_ack_l = 2'b11;
    a_din   = {32'd7, 32'd5};
    @(negedge clk);
    a_ack_l = 2'b00;
    a_req_r = 2'b11;
    check_eq("req_l_drop", 64'(a_req_l), 64'd0);
    check_eq("occ_before_push", 64'(a_occ), 64'd0);
    @(negedge clk);
    check_eq("occ_after_push", 64'(a_occ), 64'd1);
    check_eq("no_early_ack", 64'(a_ack_r), 64'd0);
    check_eq("count_one", 64'(a_cnt), 64'd1);
    @(negedge clk);
    check_eq("ack_both", 64'(a_ack_r), 64'h3);
    check_eq("add_dout", 64'(a_dout), 64'd12);
    @(negedge clk);
    check_eq("ack_single_cycle", 64'(a_ack_r), 64'd0);
    check_eq("occ_after_pop", 64'(a_occ), 64'd0);
    check_eq("empty_holds_dout", 64'(a_dout), 64'd12);

    // Consumer 1 joins late: buffer fills, operands stall, first pop waits for consumer 1
    do_reset();
    base_k  = 1;
    a_req_r = 2'b01;
    for (int c = 0; c < 40; c++) begin
      if (c == 9) begin
        check_eq("fill_occ", 64'(a_occ), 64'd2);
        check_eq("fill_req_l", 64'(a_req_l), 64'd0);
        check_eq("fill_ack0_once", 64'(exp_idx[0]), 64'd1);
        check_eq("fill_no_ack1", 64'(exp_idx[1]), 64'd0);
        check_eq("fill_count", 64'(a_cnt), 64'd2);
      end
      if (c == 10) a_req_r = 2'b11;
      if (c == 11) check_eq("no_pop_before_ack1", 64'(a_cnt), 64'd2);
      if (c == 12) begin
        check_eq("pop_after_ack1", 64'(a_cnt), 64'd3);
        check_eq("push_pop_occ", 64'(a_occ), 64'd2);
      end
      step_a();
      @(negedge clk);
    end
    check_eq("late_consumer_progress", 64'(exp_idx[1] > 3), 64'd1);

    // Continuous producers and consumers: 1000 results in order, none lost or repeated
    do_reset();
    base_k  = 0;
    a_req_r = 2'b11;
    for (int c = 0; c < 8000 && (exp_idx[0] < 1000 || exp_idx[1] < 1000); c++) begin
      step_a();
      @(negedge clk);
    end
    check_eq("stream_c0", 64'(exp_idx[0]), 64'd1000);
    check_eq("stream_c1", 64'(exp_idx[1]), 64'd1000);

    // Reset with one operand captured and the head half-served
    do_reset();
    a_req_r = 2'b01;
    a_ack_l = 2'b11;
    a_din   = {32'd7, 32'd5};
    @(negedge clk);
    a_ack_l = 2'b00;
    repeat (2) @(negedge clk);
    check_eq("half_ack0", 64'(a_ack_r), 64'h1);
    a_ack_l = 2'b01;
    a_din   = {32'd0, 32'd100};
    @(negedge clk);
    a_ack_l = 2'b00;
    check_eq("half_occ", 64'(a_occ), 64'd1);
    check_eq("half_req_l", 64'(a_req_l), 64'h2);
    rst = 1'b0;
    #1;
    check_eq("async_req_l", 64'(a_req_l), 64'd0);
    check_eq("async_ack_r", 64'(a_ack_r), 64'd0);
    check_eq("async_dout", 64'(a_dout), 64'd0);
    check_eq("async_occ", 64'(a_occ), 64'd0);
    check_eq("async_count", 64'(a_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rerelease_req_l", 64'(a_req_l), 64'h3);
    a_ack_l = 2'b11;
    a_din   = {32'd2, 32'd1};
    @(negedge clk);
    a_ack_l = 2'b00;
    a_req_r = 2'b11;
    got_a = 1'b0;
    for (int c = 0; c < 10 && !got_a; c++) begin
      @(negedge clk);
      if (a_ack_r == 2'b11) got_a = 1'b1;
    end
    check_eq("fresh_ack", 64'(got_a), 64'd1);
    check_eq("fresh_dout", 64'(a_dout), 64'd3);
    check_eq("fresh_count", 64'(a_cnt), 64'd1);

    // 8-bit SUB 3 - 5 and DEPTH=1 MULI 0x60 * 3
    do_reset();
    check_eq("s_req_l", 64'(s_req_l), 64'h3);
    check_eq("m_req_l", 64'(m_req_l), 64'h1);
    s_ack_l = 2'b11;
    s_din   = {8'h05, 8'h03};
    m_ack_l = 1'b1;
    m_din   = 8'h60;
    @(negedge clk);
    s_ack_l = '0;
    m_ack_l = '0;
    s_req_r = 1'b1;
    m_req_r = 1'b1;
    got_s = 1'b0;
    got_m = 1'b0;
    for (int c = 0; c < 10 && !(got_s && got_m); c++) begin
      @(negedge clk);
      if (s_ack_r[0] && !got_s) begin
        got_s = 1'b1;
        check_eq("sub_dout", 64'(s_dout), 64'(EXP_SUB));
      end
      if (m_ack_r[0] && !got_m) begin
        got_m = 1'b1;
        check_eq("muli_dout", 64'(m_dout), 64'(EXP_MUL));
        check_eq("muli_occ", 64'(m_occ), 64'd1);
      end
    end
    check_eq("sub_acked", 64'(got_s), 64'd1);
    check_eq("muli_acked", 64'(got_m), 64'd1);
    @(negedge clk);
    check_eq("muli_empty", 64'(m_occ), 64'd0);
    check_eq("sub_count", 64'(s_cnt), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
